// File: rtl/soc_miner_pkg.sv
// Shared constants for the soc_miner register slave: AXI responses,
// register map indices and the read/write FSM state encodings.
package soc_miner_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int REG_CTRL       = 0;
  localparam int REG_STATUS     = 1;
  localparam int CTRL_START_BIT = 0;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

endpackage

// File: rtl/soc_miner_regs_burst_addr.sv
// Burst address tracker: holds the current beat address, beat counter and
// burst length, steps the address by one word per beat and reports the
// register index, range status and last-beat flag. With LOOKAHEAD set the
// reported view is the address that will be current after this cycle,
// which lets the read side register the data for the beat it is about to
// present.
module soc_miner_regs_burst_addr #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = $clog2(NUM_REGS),
  parameter bit LOOKAHEAD  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [3:0]            start_len,
  output logic [IDX_W-1:0]      idx,
  output logic                  in_range,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [ADDR_WIDTH-1:0] view_addr;
  logic [3:0]            cnt_q;
  logic [3:0]            len_q;
  logic [3:0]            nxt_cnt;
  logic [3:0]            nxt_len;
  logic [3:0]            view_cnt;
  logic [3:0]            view_len;

  // Next-state of the tracker: a load restarts the burst, an accepted beat steps it
  always_comb begin
    nxt_addr = addr_q;
    nxt_cnt  = cnt_q;
    nxt_len  = len_q;
    if (load) begin
      nxt_addr = start_addr;
      nxt_cnt  = 4'd0;
      nxt_len  = start_len;
    end else if (advance) begin
      nxt_addr = addr_q + ADDR_WIDTH'(4);
      nxt_cnt  = cnt_q + 4'd1;
    end
  end

  // Tracker registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
    end else begin
      addr_q <= nxt_addr;
      cnt_q  <= nxt_cnt;
      len_q  <= nxt_len;
    end
  end

  assign view_addr = LOOKAHEAD ? nxt_addr : addr_q;
  assign view_cnt  = LOOKAHEAD ? nxt_cnt  : cnt_q;
  assign view_len  = LOOKAHEAD ? nxt_len  : len_q;

  // The index is not masked: anything past the bank is out of range, never wrapped
  assign idx      = view_addr[2 +: IDX_W];
  assign in_range = (view_addr >> 2) < ADDR_WIDTH'(NUM_REGS);
  assign last     = (view_cnt == view_len);

endmodule

// File: rtl/soc_miner_regs_slave.sv
// AXI3 slave register bank for soc_miner. Independent write and read
// FSMs serve single and INCR bursts into NUM_REGS 32-bit registers.
// Index 0 is control (bit0 is a self-clearing start strobe), index 1
// returns the core status word, the rest are plain storage.
module soc_miner_regs_slave
  import soc_miner_pkg::*;
#(
  parameter int REGS_DATA_WIDTH = 32,
  parameter int REGS_ADDR_WIDTH = 32,
  parameter int NUM_REGS        = 16
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         s_regs_awvalid,
  output logic                         s_regs_awready,
  input  logic [REGS_ADDR_WIDTH-1:0]   s_regs_awaddr,
  input  logic [3:0]                   s_regs_awlen,
  input  logic                         s_regs_wvalid,
  output logic                         s_regs_wready,
  input  logic [REGS_DATA_WIDTH-1:0]   s_regs_wdata,
  input  logic [3:0]                   s_regs_wstrb,
  input  logic                         s_regs_wlast,
  output logic                         s_regs_bvalid,
  input  logic                         s_regs_bready,
  output logic [1:0]                   s_regs_bresp,
  input  logic                         s_regs_arvalid,
  output logic                         s_regs_arready,
  input  logic [REGS_ADDR_WIDTH-1:0]   s_regs_araddr,
  input  logic [3:0]                   s_regs_arlen,
  output logic                         s_regs_rvalid,
  input  logic                         s_regs_rready,
  output logic [REGS_DATA_WIDTH-1:0]   s_regs_rdata,
  output logic                         s_regs_rlast,
  output logic [1:0]                   s_regs_rresp,
  output logic                         ctrl_start,
  input  logic [31:0]                  status_word,
  output logic [NUM_REGS*32-1:0]       regs_q
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [REGS_DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [1:0]                 w_state;
  logic [0:0]                 r_state;
  logic                       w_err;
  logic                       aw_hs;
  logic                       w_hs;
  logic                       ar_hs;
  logic                       r_hs;
  logic [IDX_W-1:0]           wr_idx;
  logic                       wr_in_range;
  logic                       wr_last;
  logic [IDX_W-1:0]           rd_idx;
  logic                       rd_in_range;
  logic                       rd_last;
  logic [REGS_DATA_WIDTH-1:0] rd_word;

  assign aw_hs = s_regs_awvalid & s_regs_awready;
  assign w_hs  = s_regs_wvalid  & s_regs_wready;
  assign ar_hs = s_regs_arvalid & s_regs_arready;
  assign r_hs  = s_regs_rvalid  & s_regs_rready;

  soc_miner_regs_burst_addr #(
    .ADDR_WIDTH (REGS_ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .LOOKAHEAD  (1'b0)
  ) u_wr_addr (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .load       (aw_hs),
    .advance    (w_hs),
    .start_addr (s_regs_awaddr),
    .start_len  (s_regs_awlen),
    .idx        (wr_idx),
    .in_range   (wr_in_range),
    .last       (wr_last)
  );

  soc_miner_regs_burst_addr #(
    .ADDR_WIDTH (REGS_ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .LOOKAHEAD  (1'b1)
  ) u_rd_addr (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .load       (ar_hs),
    .advance    (r_hs),
    .start_addr (s_regs_araddr),
    .start_len  (s_regs_arlen),
    .idx        (rd_idx),
    .in_range   (rd_in_range),
    .last       (rd_last)
  );

  // Write channel FSM: address, data beats, then a held response
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      w_state        <= W_IDLE;
      s_regs_awready <= 1'b0;
      s_regs_wready  <= 1'b0;
      s_regs_bvalid  <= 1'b0;
      s_regs_bresp   <= RESP_OKAY;
      w_err          <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_regs_awready <= 1'b1;
          if (aw_hs) begin
            s_regs_awready <= 1'b0;
            s_regs_wready  <= 1'b1;
            w_err          <= 1'b0;
            w_state        <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (!wr_in_range) w_err <= 1'b1;
            if (s_regs_wlast || wr_last) begin
              s_regs_wready <= 1'b0;
              s_regs_bvalid <= 1'b1;
              s_regs_bresp  <= (w_err || !wr_in_range) ? RESP_SLVERR : RESP_OKAY;
              w_state       <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_regs_bready) begin
            s_regs_bvalid  <= 1'b0;
            s_regs_awready <= 1'b1;
            w_state        <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Register storage and the start strobe; status slot and out-of-range beats are dropped
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      ctrl_start <= 1'b0;
    end else begin
      ctrl_start <= 1'b0;
      if (w_hs && wr_in_range && int'(wr_idx) != REG_STATUS) begin
        for (int b = 0; b < 4; b++) begin
          if (s_regs_wstrb[b]) regs[wr_idx][8*b +: 8] <= s_regs_wdata[8*b +: 8];
        end
        if (int'(wr_idx) == REG_CTRL) begin
          regs[wr_idx][CTRL_START_BIT] <= 1'b0;
          ctrl_start <= s_regs_wstrb[0] & s_regs_wdata[CTRL_START_BIT];
        end
      end
    end
  end

  // Word for the beat about to be presented, taken before any same-edge write lands
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (int'(rd_idx) == REG_STATUS) rd_word = status_word;
      else                            rd_word = regs[rd_idx];
    end
  end

  // Read channel FSM: registered data beats, held while the master stalls
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state        <= R_IDLE;
      s_regs_arready <= 1'b0;
      s_regs_rvalid  <= 1'b0;
      s_regs_rdata   <= '0;
      s_regs_rlast   <= 1'b0;
      s_regs_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_regs_arready <= 1'b1;
          if (ar_hs) begin
            s_regs_arready <= 1'b0;
            s_regs_rvalid  <= 1'b1;
            s_regs_rdata   <= rd_word;
            s_regs_rlast   <= rd_last;
            s_regs_rresp   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            r_state        <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_regs_rready) begin
            if (s_regs_rlast) begin
              s_regs_rvalid  <= 1'b0;
              s_regs_rlast   <= 1'b0;
              s_regs_arready <= 1'b1;
              r_state        <= R_IDLE;
            end else begin
              s_regs_rdata <= rd_word;
              s_regs_rlast <= rd_last;
              s_regs_rresp <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_q[g*32 +: 32] = regs[g];
  end

endmodule
